// File: rtl/burst_write_master.sv
// Avalon-MM burst write master: a show-ahead FIFO collects user words, and a three-state FSM
// drains them as bursts of up to MAXBURSTCOUNT beats starting at the programmed word address.
module burst_write_master #(
    parameter int DATAWIDTH       = 32,
    parameter int ADDRESSWIDTH    = 32,
    parameter int MAXBURSTCOUNT   = 8,
    parameter int BURSTCOUNTWIDTH = 4,
    parameter int FIFODEPTH       = 32,
    parameter int FIFODEPTH_LOG2  = 5
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       control_fixed_location,
    input  logic [ADDRESSWIDTH-1:0]    control_write_base,
    input  logic [ADDRESSWIDTH-1:0]    control_write_length,
    input  logic                       control_go,
    output logic                       control_done,
    input  logic                       user_write_buffer,
    input  logic [DATAWIDTH-1:0]       user_buffer_data,
    output logic                       user_buffer_full,
    output logic [FIFODEPTH_LOG2:0]    user_buffer_used,
    output logic [ADDRESSWIDTH-1:0]    master_address,
    output logic                       master_write,
    output logic [DATAWIDTH/8-1:0]     master_byteenable,
    output logic [BURSTCOUNTWIDTH-1:0] master_burstcount,
    output logic [DATAWIDTH-1:0]       master_writedata,
    input  logic                       master_waitrequest
);

    localparam int USEDW = FIFODEPTH_LOG2 + 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DATA = 2'd1,
        BURST     = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [ADDRESSWIDTH-1:0]    address_q, address_d;
    logic [ADDRESSWIDTH-1:0]    length_q, length_d;
    logic                       fixed_q, fixed_d;
    logic [BURSTCOUNTWIDTH-1:0] burstcount_q, burstcount_d;
    logic [BURSTCOUNTWIDTH-1:0] beats_q, beats_d;
    logic [FIFODEPTH_LOG2-1:0]  wr_ptr_q, wr_ptr_d;
    logic [FIFODEPTH_LOG2-1:0]  rd_ptr_q, rd_ptr_d;
    logic [USEDW-1:0]           used_q, used_d;
    logic [DATAWIDTH-1:0]       mem_q [FIFODEPTH];

    logic                       full_s;
    logic                       push_s;
    logic                       pop_s;
    logic [BURSTCOUNTWIDTH-1:0] burst_len_s;
    logic                       data_ready_s;
    logic [ADDRESSWIDTH-1:0]    length_dec_s;

    assign full_s       = (used_q == USEDW'(FIFODEPTH));
    assign push_s       = user_write_buffer && !full_s;
    assign pop_s        = (state_q == BURST) && !master_waitrequest;
    assign length_dec_s = length_q - ADDRESSWIDTH'(1);
    assign data_ready_s = (used_q >= USEDW'(burst_len_s));

    assign control_done      = (length_q == ADDRESSWIDTH'(0)) && (state_q != BURST);
    assign user_buffer_full  = full_s;
    assign user_buffer_used  = used_q;
    assign master_address    = address_q;
    assign master_write      = (state_q == BURST);
    assign master_byteenable = {(DATAWIDTH/8){1'b1}};
    assign master_burstcount = burstcount_q;
    assign master_writedata  = mem_q[rd_ptr_q];

    // FIFO storage; only the write port is clocked, the head is read combinationally
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= user_buffer_data;
        end
    end

    // FIFO pointer and occupancy next-state
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        used_d   = used_q;
        if (push_s) begin
            wr_ptr_d = wr_ptr_q + FIFODEPTH_LOG2'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + FIFODEPTH_LOG2'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_s, pop_s})
            2'b10:   used_d = used_q + USEDW'(1);
            2'b01:   used_d = used_q - USEDW'(1);
            default: used_d = used_q;
        endcase
    end

    // Burst size for the next burst: clipped to the remaining length, single beats in fixed mode
    always_comb begin
        burst_len_s = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        if (fixed_q) begin
            burst_len_s = BURSTCOUNTWIDTH'(1);
        end else if (length_q < ADDRESSWIDTH'(MAXBURSTCOUNT)) begin
            burst_len_s = length_q[BURSTCOUNTWIDTH-1:0];
        end else begin
            burst_len_s = BURSTCOUNTWIDTH'(MAXBURSTCOUNT);
        end
    end

    // Transfer FSM next-state; control_go is only looked at in IDLE
    always_comb begin
        state_d      = state_q;
        address_d    = address_q;
        length_d     = length_q;
        fixed_d      = fixed_q;
        burstcount_d = burstcount_q;
        beats_d      = beats_q;
        case (state_q)
            IDLE: begin
                if (control_go) begin
                    address_d = control_write_base;
                    length_d  = control_write_length;
                    fixed_d   = control_fixed_location;
                    state_d   = (control_write_length != ADDRESSWIDTH'(0)) ? WAIT_DATA : IDLE;
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT_DATA: begin
                if (data_ready_s) begin
                    burstcount_d = burst_len_s;
                    beats_d      = burst_len_s;
                    state_d      = BURST;
                end else begin
                    state_d = WAIT_DATA;
                end
            end
            BURST: begin
                if (!master_waitrequest) begin
                    length_d = length_dec_s;
                    beats_d  = beats_q - BURSTCOUNTWIDTH'(1);
                    if (beats_q == BURSTCOUNTWIDTH'(1)) begin
                        address_d = fixed_q ? address_q
                                            : address_q + ADDRESSWIDTH'(burstcount_q);
                        state_d   = (length_dec_s != ADDRESSWIDTH'(0)) ? WAIT_DATA : IDLE;
                    end else begin
                        state_d = BURST;
                    end
                end else begin
                    state_d = BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers with asynchronous clear
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            address_q    <= '0;
            length_q     <= '0;
            fixed_q      <= 1'b0;
            burstcount_q <= '0;
            beats_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            used_q       <= '0;
        end else begin
            state_q      <= state_d;
            address_q    <= address_d;
            length_q     <= length_d;
            fixed_q      <= fixed_d;
            burstcount_q <= burstcount_d;
            beats_q      <= beats_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            used_q       <= used_d;
        end
    end

endmodule

// File: tb/tb_burst_write_master.sv
// Directed bench for burst_write_master: a table of transfers with expected burst layouts,
// plus hand sequences for trickle fill, FIFO overflow, go-while-busy and mid-burst reset.
module tb_burst_write_master;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        control_fixed_location = 1'b0;
    logic [31:0] control_write_base = 32'h0;
    logic [31:0] control_write_length = 32'h0;
    logic        control_go = 1'b0;
    logic        control_done;
    logic        user_write_buffer = 1'b0;
    logic [31:0] user_buffer_data = 32'h0;
    logic        user_buffer_full;
    logic [5:0]  user_buffer_used;
    logic [31:0] master_address;
    logic        master_write;
    logic [3:0]  master_byteenable;
    logic [3:0]  master_burstcount;
    logic [31:0] master_writedata;
    logic        master_waitrequest = 1'b0;

    burst_write_master dut (
        .clk                    (clk),
        .reset                  (reset),
        .control_fixed_location (control_fixed_location),
        .control_write_base     (control_write_base),
        .control_write_length   (control_write_length),
        .control_go             (control_go),
        .control_done           (control_done),
        .user_write_buffer      (user_write_buffer),
        .user_buffer_data       (user_buffer_data),
        .user_buffer_full       (user_buffer_full),
        .user_buffer_used       (user_buffer_used),
        .master_address         (master_address),
        .master_write           (master_write),
        .master_byteenable      (master_byteenable),
        .master_burstcount      (master_burstcount),
        .master_writedata       (master_writedata),
        .master_waitrequest     (master_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] len;
        logic        fixed;
        int          npush;
        int          stall_beat;
        int          stall_cycles;
        int          nbursts;
        logic [31:0] exp_addr [4];
        logic [3:0]  exp_bc   [4];
    } case_t;

    case_t       cases [5];
    logic [31:0] exp_q [$];
    logic [31:0] word_ctr = 32'hA000_0000;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one push for the coming edge and record it in the model if the FIFO has room.
    task automatic push_word();
        user_write_buffer = 1'b1;
        user_buffer_data  = word_ctr;
        if (exp_q.size() < 32) exp_q.push_back(word_ctr);
        word_ctr = word_ctr + 32'd1;
    endtask

    task automatic check_beat_data(input string name);
        if (exp_q.size() == 0) chk({name, "_extra_beat"}, 64'd1, 64'd0);
        else chk(name, master_writedata, exp_q.pop_front());
    endtask

    task automatic run_case(input int ci);
        int  bidx, left, stall, beats;
        bit  done_seen;
        for (int i = 0; i < cases[ci].npush; i++) begin
            @(negedge clk);
            push_word();
        end
        @(negedge clk);
        user_write_buffer = 1'b0;
        chk("used_before_go", user_buffer_used, exp_q.size());
        control_go             = 1'b1;
        control_write_base     = cases[ci].base;
        control_write_length   = cases[ci].len;
        control_fixed_location = cases[ci].fixed;
        @(negedge clk);
        control_go = 1'b0;
        bidx = 0; left = 0; beats = 0; done_seen = 1'b0;
        stall = cases[ci].stall_cycles;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (cyc > 0) @(negedge clk);
            master_waitrequest = 1'b0;
            if (control_done) begin
                done_seen = 1'b1;
                break;
            end
            if (master_write) begin
                if (left == 0) begin
                    left = int'(master_burstcount);
                    bidx++;
                end
                if (bidx <= 4) begin
                    chk("burst_addr", master_address, cases[ci].exp_addr[bidx-1]);
                    chk("burst_count", master_burstcount, cases[ci].exp_bc[bidx-1]);
                end
                if (beats == cases[ci].stall_beat && stall > 0) begin
                    master_waitrequest = 1'b1;
                    stall--;
                    chk("stall_used", user_buffer_used, exp_q.size());
                end else begin
                    check_beat_data("beat_data");
                    beats++;
                    left--;
                end
            end
        end
        master_waitrequest = 1'b0;
        chk("case_done", done_seen, 1);
        chk("case_beats", beats, cases[ci].len);
        chk("case_bursts", bidx, cases[ci].nbursts);
        chk("case_used_end", user_buffer_used, exp_q.size());
        chk("case_write_idle", master_write, 0);
    endtask

    initial begin
        cases[0] = '{base: 32'h100, len: 32'd20, fixed: 1'b0, npush: 20, stall_beat: -1, stall_cycles: 0,
                     nbursts: 3, exp_addr: '{32'h100, 32'h108, 32'h110, 32'h0},
                     exp_bc: '{4'd8, 4'd8, 4'd4, 4'd0}};
        cases[1] = '{base: 32'h40, len: 32'd4, fixed: 1'b1, npush: 4, stall_beat: -1, stall_cycles: 0,
                     nbursts: 4, exp_addr: '{32'h40, 32'h40, 32'h40, 32'h40},
                     exp_bc: '{4'd1, 4'd1, 4'd1, 4'd1}};
        cases[2] = '{base: 32'hFFFF_FFFC, len: 32'd10, fixed: 1'b0, npush: 10, stall_beat: -1, stall_cycles: 0,
                     nbursts: 2, exp_addr: '{32'hFFFF_FFFC, 32'h4, 32'h0, 32'h0},
                     exp_bc: '{4'd8, 4'd2, 4'd0, 4'd0}};
        cases[3] = '{base: 32'h80, len: 32'd8, fixed: 1'b0, npush: 8, stall_beat: 3, stall_cycles: 5,
                     nbursts: 1, exp_addr: '{32'h80, 32'h0, 32'h0, 32'h0},
                     exp_bc: '{4'd8, 4'd0, 4'd0, 4'd0}};
        cases[4] = '{base: 32'h20, len: 32'd3, fixed: 1'b0, npush: 3, stall_beat: 0, stall_cycles: 2,
                     nbursts: 1, exp_addr: '{32'h20, 32'h0, 32'h0, 32'h0},
                     exp_bc: '{4'd3, 4'd0, 4'd0, 4'd0}};

        // Reset state
        #1 reset = 1'b1;
        #2;
        chk("rst_done", control_done, 1);
        chk("rst_write", master_write, 0);
        chk("rst_used", user_buffer_used, 0);
        chk("rst_full", user_buffer_full, 0);
        chk("rst_bc", master_burstcount, 0);
        chk("rst_addr", master_address, 0);
        chk("byteenable", master_byteenable, 4'hF);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int ci = 0; ci < 5; ci++) run_case(ci);

        // Trickle fill: no write until eight words are buffered, then eight back-to-back beats
        @(negedge clk);
        control_go = 1'b1; control_write_base = 32'h200; control_write_length = 32'd8;
        control_fixed_location = 1'b0;
        @(negedge clk);
        control_go = 1'b0;
        for (int k = 0; k < 8; k++) begin
            push_word();
            chk("trickle_nowrite_a", master_write, 0);
            @(negedge clk);
            user_write_buffer = 1'b0;
            chk("trickle_nowrite_b", master_write, 0);
            if (k < 7) begin
                @(negedge clk);
                chk("trickle_nowrite_c", master_write, 0);
                @(negedge clk);
            end
        end
        chk("trickle_used8", user_buffer_used, 8);
        for (int b = 0; b < 8; b++) begin
            @(negedge clk);
            chk("trickle_write", master_write, 1);
            chk("trickle_addr", master_address, 32'h200);
            chk("trickle_bc", master_burstcount, 8);
            check_beat_data("trickle_data");
        end
        @(negedge clk);
        chk("trickle_end_write", master_write, 0);
        chk("trickle_end_done", control_done, 1);

        // Overflow: 33 pushes into an empty FIFO, then a zero-length go
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            push_word();
        end
        @(negedge clk);
        user_write_buffer = 1'b0;
        chk("ovf_full", user_buffer_full, 1);
        chk("ovf_used", user_buffer_used, 32);
        control_go = 1'b1; control_write_base = 32'h700; control_write_length = 32'd0;
        @(negedge clk);
        control_go = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("len0_done", control_done, 1);
            chk("len0_write", master_write, 0);
            chk("len0_used", user_buffer_used, 32);
            @(negedge clk);
        end

        // Go while bursting is ignored; reset mid-burst clears everything at once
        control_go = 1'b1; control_write_base = 32'h500; control_write_length = 32'd32;
        @(negedge clk);
        control_go = 1'b0;
        for (int i = 0; i < 20 && !master_write; i++) @(negedge clk);
        chk("c_write_start", master_write, 1);
        for (int b = 0; b < 2; b++) begin
            check_beat_data("c_beat_data");
            @(negedge clk);
        end
        master_waitrequest = 1'b1;
        control_go = 1'b1; control_write_base = 32'h900; control_write_length = 32'd5;
        control_fixed_location = 1'b1;
        @(negedge clk);
        control_go = 1'b0; control_fixed_location = 1'b0;
        chk("c_busy_write", master_write, 1);
        chk("c_busy_addr", master_address, 32'h500);
        chk("c_busy_bc", master_burstcount, 8);
        chk("c_busy_used", user_buffer_used, 30);
        check_beat_data("c_busy_data");
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_write", master_write, 0);
        chk("mid_rst_done", control_done, 1);
        chk("mid_rst_used", user_buffer_used, 0);
        chk("mid_rst_full", user_buffer_full, 0);
        chk("mid_rst_bc", master_burstcount, 0);
        @(negedge clk);
        reset = 1'b0;
        master_waitrequest = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("post_rst_done", control_done, 1);
        chk("post_rst_write", master_write, 0);
        chk("post_rst_addr", master_address, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
